// File: rtl/ddr3_fifo_drain_pkg.sv
// Shared types and helpers for the DDR3 FIFO drain block: FSM encoding,
// header magic default, skid-buffer entry layout and header construction.
package ddr3_fifo_drain_pkg;

    // Packet framing FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DONE    = 2'd3
    } drain_state_t;

    // Upper 16 bits of every header word unless overridden.
    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hDA7A;

    // Two entries cover one word sitting in the buffer plus one read in flight.
    localparam int SKID_DEPTH = 2;

    // One skid-buffer entry: stream word plus its framing flags (34 bits).
    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } skid_word_t;

    // Header word: magic in the upper half, packet sequence number below.
    function automatic logic [31:0] make_header(input logic [15:0] magic,
                                                input logic [15:0] seq);
        return {magic, seq};
    endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry skid buffer for the drain stream. Entry 0 is always the head;
// a pop shifts entry 1 down and a push lands in the first free slot after
// accounting for a same-cycle pop, so push+pop keeps occupancy unchanged.
module drain_skid_buf
    import ddr3_fifo_drain_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  skid_word_t push_word,
    input  logic       pop,
    output skid_word_t head_word,
    output logic [1:0] occupancy
);

    skid_word_t entry_reg  [SKID_DEPTH];
    skid_word_t entry_next [SKID_DEPTH];
    logic [1:0] occ_reg;
    logic [1:0] occ_next;
    logic       do_pop;
    logic       do_push;
    logic [1:0] wr_idx;

    // A pop only counts when something is held; the write slot is the
    // occupancy left after that pop.
    assign do_pop  = pop && (occ_reg != 2'd0);
    assign wr_idx  = occ_reg - {1'b0, do_pop};
    // A push into a full, non-draining buffer is dropped rather than
    // corrupting the count; the top never issues one.
    assign do_push = push && (wr_idx < 2'(SKID_DEPTH));

    // Next-state of the entries and occupancy: shift on pop, then write.
    always_comb begin
        occ_next = occ_reg + {1'b0, do_push} - {1'b0, do_pop};
        for (int i = 0; i < SKID_DEPTH; i++) begin
            entry_next[i] = entry_reg[i];
        end
        if (do_pop) begin
            for (int i = 0; i < SKID_DEPTH - 1; i++) begin
                entry_next[i] = entry_reg[i + 1];
            end
            entry_next[SKID_DEPTH - 1] = '0;
        end
        if (do_push) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                if (wr_idx == 2'(i)) begin
                    entry_next[i] = push_word;
                end
            end
        end
    end

    // Entry and occupancy registers; reset clears the contents so the
    // stream outputs read as zero while in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_reg <= 2'd0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            occ_reg <= occ_next;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                entry_reg[i] <= entry_next[i];
            end
        end
    end

    assign head_word = entry_reg[0];
    assign occupancy = occ_reg;

endmodule

// File: rtl/ddr3_fifo_drain.sv
// Drains the DDR3 FIFO read port and frames the words into fixed-length
// packets (one header word plus PKT_WORDS payload words) on a valid/ready
// stream. A 2-entry skid buffer absorbs the FIFO read latency and
// downstream backpressure.
module ddr3_fifo_drain
    import ddr3_fifo_drain_pkg::*;
#(
    parameter int          PKT_WORDS = 64,
    parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        calib_done,
    output logic        rd_stb,
    input  logic [31:0] rd_data,
    input  logic        rd_empty,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic        busy,
    output logic        stall,
    output logic [15:0] pkt_count
);

    localparam int            CW          = $clog2(PKT_WORDS + 1);
    localparam logic [CW-1:0] PKT_WORDS_C = CW'(PKT_WORDS);
    localparam logic [CW-1:0] LAST_IDX    = CW'(PKT_WORDS - 1);

    drain_state_t  state_reg;
    drain_state_t  state_next;
    logic [15:0]   seq_reg;
    logic [15:0]   pkt_count_reg;
    logic [CW-1:0] req_cnt_reg;
    logic [CW-1:0] rcv_cnt_reg;
    logic          inflight_reg;

    logic          hdr_push;
    logic          buf_push;
    skid_word_t    buf_push_word;
    logic          buf_pop;
    skid_word_t    head_word;
    logic [1:0]    buf_occ;
    logic [2:0]    eff_occ;
    logic          room;
    logic          words_left;
    logic          rd_stb_int;
    logic          eof_xfer;

    drain_skid_buf u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (buf_push),
        .push_word (buf_push_word),
        .pop       (buf_pop),
        .head_word (head_word),
        .occupancy (buf_occ)
    );

    assign out_valid = (buf_occ != 2'd0);
    assign out_data  = head_word.data;
    assign out_sof   = head_word.sof;
    assign out_eof   = head_word.eof;
    assign buf_pop   = out_valid && out_ready;
    assign eof_xfer  = buf_pop && head_word.eof;

    // Slots committed after this cycle: held words plus the in-flight read,
    // minus the word leaving now. Counting the departing word is what lets
    // a ready sink see one word per cycle instead of two in three.
    assign eff_occ    = {1'b0, buf_occ} + {2'b00, inflight_reg} - {2'b00, buf_pop};
    assign room       = (eff_occ < 3'd2);
    assign words_left = (req_cnt_reg != PKT_WORDS_C);

    assign rd_stb_int = (state_reg == ST_PAYLOAD) && !rd_empty && room && words_left;
    assign rd_stb     = rd_stb_int;
    assign stall      = (state_reg == ST_PAYLOAD) && rd_empty && room && words_left;
    assign busy       = (state_reg != ST_IDLE);
    assign pkt_count  = pkt_count_reg;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and header push request.
    always_comb begin
        state_next = state_reg;
        hdr_push   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable && calib_done && !rd_empty) begin
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                // Header only enters an empty buffer so it can never be
                // overtaken by payload from the previous packet.
                if ((buf_occ == 2'd0) && !inflight_reg) begin
                    hdr_push   = 1'b1;
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (rd_stb_int && (req_cnt_reg == LAST_IDX)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (eof_xfer) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Buffer write source: the returning FIFO word always wins, since a
    // read in flight must be captured; the header only goes in when idle.
    always_comb begin
        buf_push      = 1'b0;
        buf_push_word = '0;
        if (inflight_reg) begin
            buf_push           = 1'b1;
            buf_push_word.data = rd_data;
            buf_push_word.eof  = (rcv_cnt_reg == LAST_IDX);
        end else if (hdr_push) begin
            buf_push           = 1'b1;
            buf_push_word.data = make_header(HDR_MAGIC, seq_reg);
            buf_push_word.sof  = 1'b1;
        end
    end

    // Request/receive counters, in-flight flag, sequence and packet count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_cnt_reg   <= '0;
            rcv_cnt_reg   <= '0;
            inflight_reg  <= 1'b0;
            seq_reg       <= 16'd0;
            pkt_count_reg <= 16'd0;
        end else begin
            inflight_reg <= rd_stb_int;
            if (state_reg == ST_HEADER) begin
                req_cnt_reg <= '0;
                rcv_cnt_reg <= '0;
            end else begin
                if (rd_stb_int) begin
                    req_cnt_reg <= req_cnt_reg + CW'(1);
                end
                if (inflight_reg) begin
                    rcv_cnt_reg <= rcv_cnt_reg + CW'(1);
                end
            end
            if ((state_reg == ST_DONE) && eof_xfer) begin
                seq_reg       <= seq_reg + 16'd1;
                pkt_count_reg <= pkt_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_fifo_drain.sv
// Bench for ddr3_fifo_drain: a FIFO model feeds the block, a monitor logs
// every stream transfer, and the expected stream is built from the packet
// framing rules (header {DA7A, seq}, then PKT words in FIFO order, last eof).
module tb_ddr3_fifo_drain;

    localparam int PKT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        calib_done = 1'b1;
    logic        rd_stb;
    logic [31:0] rd_data = 32'd0;
    logic        rd_empty;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sof;
    logic        out_eof;
    logic        busy;
    logic        stall;
    logic [15:0] pkt_count;

    ddr3_fifo_drain #(.PKT_WORDS(PKT), .HDR_MAGIC(16'hDA7A)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .calib_done (calib_done),
        .rd_stb     (rd_stb),
        .rd_data    (rd_data),
        .rd_empty   (rd_empty),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .busy       (busy),
        .stall      (stall),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic bp_mode = 1'b0;

    // FIFO model: registered read, data valid the cycle after rd_stb.
    logic [31:0] fifo_mem [0:4095];
    int fifo_wr = 0;
    int fifo_rd = 0;
    assign rd_empty = (fifo_wr == fifo_rd);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_stb) begin
            rd_data <= fifo_mem[fifo_rd];
            fifo_rd <= fifo_rd + 1;
        end
    end

    // Stream monitor, sampled on the falling edge.
    logic [33:0] rx_q [$];
    int          rx_cyc [$];
    int          stb_count = 0;
    int          stb_err = 0;
    int          hold_err = 0;
    logic        hold_pending = 1'b0;
    logic [33:0] hold_word = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (hold_pending && (!out_valid || ({out_data, out_sof, out_eof} !== hold_word)))
                hold_err <= hold_err + 1;
            hold_pending <= out_valid && !out_ready;
            hold_word    <= {out_data, out_sof, out_eof};
            if (out_valid && out_ready) begin
                rx_q.push_back({out_data, out_sof, out_eof});
                rx_cyc.push_back(cyc);
            end
            if (rd_stb) stb_count <= stb_count + 1;
            if (rd_stb && (rd_empty || !busy)) stb_err <= stb_err + 1;
        end
    end

    // Reference model state.
    logic [33:0] exp_q [$];
    int exp_rd = 0;
    int next_seq = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[fifo_wr] = w;
        fifo_wr = fifo_wr + 1;
    endtask

    // One packet as the framing rules say it must appear on the stream.
    task automatic add_packet();
        exp_q.push_back({16'hDA7A, 16'(next_seq), 1'b1, 1'b0});
        for (int i = 0; i < PKT; i++) begin
            exp_q.push_back({fifo_mem[exp_rd], 1'b0, (i == PKT - 1)});
            exp_rd++;
        end
        next_seq++;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            step();
            t++;
        end
        check({tag, "_in_time"}, 64'(rx_q.size() >= n), 64'd1);
    endtask

    task automatic verify_stream(input string tag, input int base);
        check({tag, "_len"}, 64'(rx_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < rx_q.size())
                check($sformatf("%s_word[%0d]", tag, i), 64'(rx_q[base + i]), 64'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    int base;
    int stb0;
    int t;

    initial begin
        // Reset and idle with enable low.
        for (int v = 1; v <= 8; v++) push_word(32'(v));
        steps(4);
        check("reset_outputs", 64'({rd_stb, out_valid, out_sof, out_eof, busy, stall, pkt_count, out_data}), 64'd0);
        reset_n = 1'b1;
        steps(10);
        check("idle_stb_count", 64'(stb_count), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_valid", 64'(out_valid), 64'd0);
        check("idle_pkt_count", 64'(pkt_count), 64'd0);

        // Basic packets: 1..4 then 5..8, seq 0 and 1.
        add_packet();
        add_packet();
        base = rx_q.size();
        stb0 = stb_count;
        enable = 1'b1;
        wait_rx(base + PKT + 1, 100, "basic_pkt0");
        steps(2);
        check("basic_pkt_count_1", 64'(pkt_count), 64'd1);
        check("basic_throughput", 64'(rx_cyc[base + PKT] - rx_cyc[base + 1]), 64'(PKT - 1));
        wait_rx(base + 2 * (PKT + 1), 100, "basic_pkt1");
        steps(3);
        check("basic_pkt_count_2", 64'(pkt_count), 64'd2);
        check("basic_busy_idle", 64'(busy), 64'd0);
        check("basic_stb_pulses", 64'(stb_count - stb0), 64'(2 * PKT));
        verify_stream("basic", base);

        // Backpressure: 64 payload words with a random 50% ready.
        for (int i = 0; i < 64; i++) push_word($urandom);
        for (int p = 0; p < 64 / PKT; p++) add_packet();
        base = rx_q.size();
        stb0 = stb_count;
        bp_mode = 1'b1;
        wait_rx(base + (64 / PKT) * (PKT + 1), 3000, "bp");
        bp_mode = 1'b0;
        steps(5);
        check("bp_stb_pulses", 64'(stb_count - stb0), 64'd64);
        check("bp_hold_stable", 64'(hold_err), 64'd0);
        check("bp_pkt_count", 64'(pkt_count), 64'(2 + 64 / PKT));
        verify_stream("bp", base);

        // Underrun after the 2nd word of 4.
        push_word($urandom);
        push_word($urandom);
        base = rx_q.size();
        stb0 = stb_count;
        steps(15);
        check("underrun_stall", 64'(stall), 64'd1);
        check("underrun_busy", 64'(busy), 64'd1);
        check("underrun_stb", 64'(stb_count - stb0), 64'd2);
        check("underrun_rx", 64'(rx_q.size() - base), 64'd3);
        push_word($urandom);
        push_word($urandom);
        add_packet();
        wait_rx(base + PKT + 1, 100, "underrun_resume");
        steps(10);
        check("underrun_no_pad", 64'(rx_q.size() - base), 64'(PKT + 1));
        check("underrun_stall_clear", 64'(stall), 64'd0);
        verify_stream("underrun", base);

        // enable drops after payload word 1; FIFO holds a second packet.
        for (int i = 0; i < 2 * PKT; i++) push_word($urandom);
        add_packet();
        base = rx_q.size();
        wait_rx(base + 2, 100, "drop_word1");
        enable = 1'b0;
        wait_rx(base + PKT + 1, 100, "drop_finish");
        steps(20);
        check("drop_no_new_header", 64'(rx_q.size() - base), 64'(PKT + 1));
        check("drop_busy", 64'(busy), 64'd0);
        check("drop_pkt_count", 64'(pkt_count), 64'(4 + 64 / PKT));
        verify_stream("drop", base);

        // calib_done low blocks packet start.
        calib_done = 1'b0;
        enable = 1'b1;
        base = rx_q.size();
        steps(10);
        check("calib_busy", 64'(busy), 64'd0);
        check("calib_no_rx", 64'(rx_q.size() - base), 64'd0);

        // Async reset while out_valid is high.
        for (int i = 0; i < PKT; i++) push_word($urandom);
        calib_done = 1'b1;
        t = 0;
        while (!out_valid && t < 50) begin
            step();
            t++;
        end
        check("arst_valid_seen", 64'(out_valid), 64'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_outputs_zero", 64'({rd_stb, out_valid, out_sof, out_eof, busy, stall, pkt_count, out_data}), 64'd0);
        base = rx_q.size();
        steps(3);
        reset_n = 1'b1;
        exp_rd = fifo_rd;
        next_seq = 0;
        add_packet();
        wait_rx(base + PKT + 1, 100, "arst_pkt");
        steps(2);
        check("arst_pkt_count", 64'(pkt_count), 64'd1);
        verify_stream("arst", base);
        enable = 1'b0;
        steps(10);

        check("rd_stb_protocol", 64'(stb_err), 64'd0);
        check("hold_stable_total", 64'(hold_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_fifo_drain.md
Name: ddr3_fifo_drain

Overview:
- Consumer for the read port of the DDR3 FIFO wrapper (rd_stb/rd_data/rd_empty), running in the rd_clk domain.
- Pops 32-bit words, frames them into fixed-length packets with a header word, and drives a valid/ready stream toward the downstream packetizer (UDP/GPIF path).
- Absorbs the FIFO's 1-cycle read latency and downstream backpressure through a 2-entry skid buffer.

Parameters:
- PKT_WORDS, 64, payload words per packet; legal range 1..65535.
- HDR_MAGIC, 16'hDA7A, upper 16 bits of every header word.

Ports:
- clk  in  1  read-side clock; same net as the FIFO rd_clk.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; allows new packets to start.
- calib_done  in  1  DDR3 calibration complete; no packet starts while low.
- rd_stb  out  1  FIFO pop strobe.
- rd_data  in  32  FIFO data; valid on the cycle after rd_stb.
- rd_empty  in  1  FIFO empty.
- out_data  out  32  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a transfer occurs when out_valid and out_ready are both high.
- out_sof  out  1  marks the header word.
- out_eof  out  1  marks the last payload word.
- busy  out  1  high from the IDLE exit until the EOF transfer.
- stall  out  1  high in PAYLOAD while popping is blocked only by rd_empty.
- pkt_count  out  16  number of completed packets; wraps.

Behaviour:
- Reset: all outputs are 0. Seq, counters and the buffer are cleared, and the FSM enters IDLE asynchronously. After release, the first packet has seq 0.
- FSM states: IDLE, HEADER, PAYLOAD, DONE.
- IDLE -> HEADER when enable && calib_done && !rd_empty.
- HEADER: write {HDR_MAGIC, seq} with sof=1 into the skid buffer.
  - The header enters only when the buffer is empty; then move to PAYLOAD.
  - The header is the first word of the packet; it never reorders with payload.
- PAYLOAD: assert rd_stb when all of the following hold:
  - !rd_empty;
  - (buffer occupancy + in-flight reads) < 2;
  - requested words < PKT_WORDS.
- Each returned rd_data word is captured into the buffer on the cycle after its rd_stb. The word whose index is PKT_WORDS-1 is tagged eof=1.
- After all PKT_WORDS words are requested, go to DONE.
- DONE: wait for the EOF word to transfer, then:
  - increment seq and pkt_count (both mod 2^16);
  - return to IDLE;
  - the next HEADER may start on the following cycle.
- Skid buffer behaviour:
  - out_valid is high whenever occupancy > 0.
  - out_data, out_sof and out_eof come from the head entry and are held stable while out_valid && !out_ready.
  - A simultaneous push and pop keeps occupancy unchanged.
- Throughput: with out_ready held high and the FIFO never empty, one word transfers per cycle after a 2-cycle fill latency. Latency is 1 cycle from the HEADER entry to out_valid.
- Stall handling: if rd_empty rises mid-packet, the block stalls and does not pad. stall=1 while blocked, and the packet resumes when rd_empty falls.
- enable or calib_done falling mid-packet: the current packet completes; no new packet starts.
- rd_stb is never asserted while rd_empty=1 or outside PAYLOAD.
- An in-flight read is always captured; the buffer never overflows.
- Counters: word counters are $clog2(PKT_WORDS+1) bits wide.

Decomposition:
- Shared package holds:
  - the FSM state encoding;
  - the HDR_MAGIC default;
  - a header-word construction function, {magic, seq}.
- One natural sub-module, drain_skid_buf: 2-entry, 34-bit (data, sof, eof) buffer with push/pop/occupancy.
- FSM and counters stay in the top module.

Test Plan:
- Reset and idle: hold reset_n low, then release with enable=0. Required: all outputs 0, rd_stb never asserted.
- Basic packet: PKT_WORDS=4; FIFO preloaded with 1,2,3,4; enable=1, calib_done=1, out_ready=1.
  - Required stream: DA7A0000(sof), 1, 2, 3, 4(eof).
  - pkt_count=1; the second packet header is DA7A0001.
- Backpressure: toggle out_ready with a random 50% duty cycle during a 64-word packet.
  - Required: no loss or duplication, data held stable while stalled, exactly 64 rd_stb pulses.
- FIFO underrun: rd_empty=1 after the 2nd of 4 words.
  - Required: stall=1, no rd_stb; after refill the packet completes with the correct eof and no padding.
- enable drops mid-packet: deassert enable after word 1.
  - Required: the packet finishes with eof, the FSM returns to IDLE, busy=0, no new header.
- Async reset mid-packet: pull reset_n low while out_valid=1.
  - Required: outputs go to 0 immediately; after release the next header carries seq 0.
